// File: rtl/top.sv
// rtl/top.sv - AXI4-Lite master FSM driving an internal AXI4-Lite slave register file.
// Optional macro AXIL_ADDR_CHECK_EN: out-of-range addresses answer SLVERR instead of aliasing.
module top #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata_in,
   output logic [DATA_W-1:0] rdata_out,
   output logic              read_done,
   output logic              write_done,
   output logic              busy,
   output logic              error
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int STRB_W = DATA_W / 8;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_REQ  = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_REQ  = 3'd3;
   localparam logic [2:0] RD_RESP = 3'd4;

   logic [2:0]        state;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;

   logic              aw_valid, aw_ready;
   logic [ADDR_W-1:0] aw_addr;
   logic              w_valid, w_ready;
   logic [DATA_W-1:0] w_data;
   logic [STRB_W-1:0] w_strb;
   logic              b_valid, b_ready;
   logic [1:0]        b_resp;
   logic              ar_valid, ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic              r_valid, r_ready;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_resp;

   // Master channel outputs decode straight from state, so payload stays stable until READY.
   assign aw_valid = (state == WR_REQ);
   assign w_valid  = (state == WR_REQ);
   assign aw_addr  = req_addr;
   assign w_data   = req_data;
   assign w_strb   = '1;
   assign b_ready  = (state == WR_RESP);
   assign ar_valid = (state == RD_REQ);
   assign ar_addr  = req_addr;
   assign r_ready  = (state == RD_RESP);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         req_addr   <= '0;
         req_data   <= '0;
         rdata_out  <= '0;
         read_done  <= 1'b0;
         write_done <= 1'b0;
         error      <= 1'b0;
      end else begin
         read_done  <= 1'b0;
         write_done <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_en) begin
                  req_addr <= addr;
                  req_data <= wdata_in;
                  state    <= WR_REQ;
               end else if (rd_en) begin
                  req_addr <= addr;
                  state    <= RD_REQ;
               end
            end
            WR_REQ: begin
               if (aw_valid && aw_ready && w_valid && w_ready) state <= WR_RESP;
            end
            WR_RESP: begin
               if (b_valid && b_ready) begin
                  write_done <= 1'b1;
                  error      <= b_resp[1];
                  state      <= IDLE;
               end
            end
            RD_REQ: begin
               if (ar_valid && ar_ready) state <= RD_RESP;
            end
            RD_RESP: begin
               if (r_valid && r_ready) begin
                  rdata_out <= r_data;
                  read_done <= 1'b1;
                  error     <= r_resp[1];
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [IDX_W-1:0]  aw_idx, ar_idx;
   logic              aw_bad, ar_bad;
   logic              unused_bits;

   assign aw_idx = aw_addr[2 +: IDX_W];
   assign ar_idx = ar_addr[2 +: IDX_W];

`ifdef AXIL_ADDR_CHECK_EN
   assign aw_bad      = |aw_addr[ADDR_W-1:2+IDX_W];
   assign ar_bad      = |ar_addr[ADDR_W-1:2+IDX_W];
   assign unused_bits = ^{aw_addr[1:0], ar_addr[1:0]};
`else
   assign aw_bad      = 1'b0;
   assign ar_bad      = 1'b0;
   assign unused_bits = ^{aw_addr[ADDR_W-1:2+IDX_W], aw_addr[1:0],
                          ar_addr[ADDR_W-1:2+IDX_W], ar_addr[1:0]};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         b_valid  <= 1'b0;
         b_resp   <= 2'b00;
         ar_ready <= 1'b0;
         r_valid  <= 1'b0;
         r_resp   <= 2'b00;
         r_data   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         ar_ready <= 1'b0;

         // AW and W are only accepted together, one cycle after both are presented.
         if (aw_valid && w_valid && !aw_ready && !b_valid) begin
            aw_ready <= 1'b1;
            w_ready  <= 1'b1;
         end
         if (aw_valid && aw_ready && w_valid && w_ready) begin
            if (!aw_bad) begin
               for (int b = 0; b < STRB_W; b++)
                  if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
            b_valid <= 1'b1;
            b_resp  <= aw_bad ? 2'b10 : 2'b00;
         end else if (b_valid && b_ready) begin
            b_valid <= 1'b0;
         end

         if (ar_valid && !ar_ready && !r_valid) ar_ready <= 1'b1;
         if (ar_valid && ar_ready) begin
            r_valid <= 1'b1;
            r_data  <= ar_bad ? '0 : regs[ar_idx];
            r_resp  <= ar_bad ? 2'b10 : 2'b00;
         end else if (r_valid && r_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - self-checking bench for top: vector table, corner sequences, randomized model check.
module tb_top;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              wr_en = 1'b0;
   logic              rd_en = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] wdata_in = '0;
   logic [DATA_W-1:0] rdata_out;
   logic              read_done, write_done, busy, error;

   top #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata_in(wdata_in), .rdata_out(rdata_out), .read_done(read_done),
      .write_done(write_done), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] model [NUM_REGS];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic bit model_bad(input logic [31:0] a);
`ifdef AXIL_ADDR_CHECK_EN
      return (a / (4 * NUM_REGS)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int model_idx(input logic [31:0] a);
      return int'((a / 4) % NUM_REGS);
   endfunction

   // Issues one request and waits for its done pulse; lat counts edges after the sampling edge.
   task automatic txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output bit got_wr, output bit got_rd, output bit busy_ok);
      @(negedge clk);
      wr_en = wr; rd_en = rd; addr = a; wdata_in = d;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; addr = $urandom; wdata_in = $urandom;
      busy_ok = busy;
      lat = -1; got_wr = 1'b0; got_rd = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (write_done || read_done) begin
            lat = i; got_wr = write_done; got_rd = read_done;
            if (busy) busy_ok = 1'b0;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
   endtask

   task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d, input bit exp_err);
      int lat; bit gw, gr, bok;
      txn(1'b1, 1'b0, a, d, lat, gw, gr, bok);
      check({tag, "_lat"}, lat, 3);
      check({tag, "_done"}, {gw, gr}, 2'b10);
      check({tag, "_busy"}, bok, 1'b1);
      check({tag, "_err"}, error, exp_err);
      if (!model_bad(a)) model[model_idx(a)] = d;
   endtask

   task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input bit exp_err);
      int lat; bit gw, gr, bok;
      txn(1'b0, 1'b1, a, 32'h0, lat, gw, gr, bok);
      check({tag, "_lat"}, lat, 3);
      check({tag, "_done"}, {gw, gr}, 2'b01);
      check({tag, "_busy"}, bok, 1'b1);
      check({tag, "_data"}, rdata_out, exp_d);
      check({tag, "_err"}, error, exp_err);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_d;
      bit          exp_err;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int lat; bit gw, gr, bok;
      logic [31:0] ra, rd_v;

      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

      #1;
      check("rst_rdata", rdata_out, 32'h0);
      check("rst_flags", {read_done, write_done, busy, error}, 4'b0000);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      tbl[0] = '{1'b1, 32'h10, 32'hAABBCCDD, 32'h0, 1'b0};
      tbl[1] = '{1'b0, 32'h10, 32'h0, 32'hAABBCCDD, 1'b0};
      tbl[2] = '{1'b0, 32'h04, 32'h0, 32'h0, 1'b0};
      tbl[3] = '{1'b1, 32'h00, 32'hCAFEF00D, 32'h0, 1'b0};
      tbl[4] = '{1'b1, 32'h3C, 32'h11112222, 32'h0, 1'b0};
      tbl[5] = '{1'b0, 32'h3F, 32'h0, 32'h11112222, 1'b0};
`ifdef AXIL_ADDR_CHECK_EN
      tbl[6] = '{1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1};
      tbl[7] = '{1'b0, 32'h100, 32'h0, 32'h0, 1'b1};
      tbl[8] = '{1'b0, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0};
`else
      tbl[6] = '{1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0};
      tbl[7] = '{1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0};
      tbl[8] = '{1'b0, 32'h00, 32'h0, 32'hDEADBEEF, 1'b0};
`endif
      foreach (tbl[i]) begin
         if (tbl[i].wr) do_write($sformatf("tbl%0d_wr", i), tbl[i].a, tbl[i].d, tbl[i].exp_err);
         else           do_read($sformatf("tbl%0d_rd", i), tbl[i].a, tbl[i].exp_d, tbl[i].exp_err);
      end
      @(posedge clk); #1;
      check("done_is_pulse", {read_done, write_done}, 2'b00);

      // Simultaneous wr_en and rd_en: write wins, read is dropped rather than queued.
      txn(1'b1, 1'b1, 32'h08, 32'h12345678, lat, gw, gr, bok);
      check("both_lat", lat, 3);
      check("both_done", {gw, gr}, 2'b10);
      model[2] = 32'h12345678;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("both_no_read", {read_done, busy}, 2'b00);
      end
      do_read("both_rd08", 32'h08, 32'h12345678, 1'b0);

      // wr_en pulsed while busy must be ignored.
      @(negedge clk);
      wr_en = 1'b1; addr = 32'h0C; wdata_in = 32'h00000001;
      @(posedge clk); #1;
      addr = 32'h14; wdata_in = 32'h00000055;
      repeat (2) @(posedge clk);
      #1; wr_en = 1'b0;
      @(posedge clk); #1;
      check("ign_done", write_done, 1'b1);
      @(posedge clk); #1;
      check("ign_idle", {busy, write_done}, 2'b00);
      model[3] = 32'h1;
      do_read("ign_rd14", 32'h14, model[5], 1'b0);
      do_read("ign_rd0c", 32'h0C, 32'h1, 1'b0);

      for (int n = 0; n < 200; n++) begin
         ra = 32'($urandom_range(0, NUM_REGS * 4 - 1));
         if ($urandom_range(0, 3) == 0) ra = ra | (32'($urandom_range(1, 255)) << 8);
         if ($urandom_range(0, 1) == 1) begin
            rd_v = $urandom;
            do_write($sformatf("rnd%0d_wr", n), ra, rd_v, model_bad(ra));
         end else begin
            do_read($sformatf("rnd%0d_rd", n), ra,
                    model_bad(ra) ? 32'h0 : model[model_idx(ra)], model_bad(ra));
         end
      end

      // Reset while the write waits in WR_RESP: no done pulse, everything cleared.
      @(negedge clk);
      wr_en = 1'b1; addr = 32'h20; wdata_in = 32'h5A5A5A5A;
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      check("rst_mid_rdata", rdata_out, 32'h0);
      check("rst_mid_flags", {read_done, write_done, busy, error}, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rst_mid_nodone", {read_done, write_done}, 2'b00);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      do_read("post_rst_rd20", 32'h20, 32'h0, 1'b0);
      do_read("post_rst_rd10", 32'h10, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter ADDR_W, default 32: user and AXI address width.
REQ-002 Parameter DATA_W, default 32: data width; only 32 is supported.
REQ-003 Parameter NUM_REGS, default 16: number of 32-bit slave registers; must be a power of two.
REQ-004 clk  input  1  single clock; all logic is rising-edge triggered.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  write request strobe, sampled on the rising edge.
REQ-007 rd_en  input  1  read request strobe, sampled on the rising edge.
REQ-008 addr  input  ADDR_W  byte address, captured with the request.
REQ-009 wdata_in  input  DATA_W  write data, captured with wr_en.
REQ-010 rdata_out  output  DATA_W  last read data; held until the next read completes.
REQ-011 read_done  output  1  one-cycle pulse when a read completes.
REQ-012 write_done  output  1  one-cycle pulse when a write completes.
REQ-013 busy  output  1  high while a transaction is in flight.
REQ-014 error  output  1  response error of the last completed transaction.

Function
REQ-015 The block SHALL contain an AXI4-Lite master FSM and an AXI4-Lite slave register file, joined by internal AW/W/B/AR/R channels (VALID/READY, BRESP/RRESP 2 bits, OKAY=00, SLVERR=10).
REQ-016 Master states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP; every transaction returns to IDLE.
REQ-017 In IDLE, wr_en=1 SHALL capture addr and wdata_in and go to WR_REQ; else rd_en=1 SHALL capture addr and go to RD_REQ. Write has priority when both are high; the read is dropped.
REQ-018 wr_en and rd_en SHALL be ignored while not in IDLE.
REQ-019 Write timing, with request sampled at edge T: AWVALID and WVALID high from T+1; slave AWREADY and WREADY registered high at T+2 (handshake); BVALID high at T+3 with BREADY high (handshake); write_done=1 for the cycle after T+4; return to IDLE.
REQ-020 Read timing: ARVALID high from T+1; ARREADY at T+2; RVALID with RDATA at T+3 with RREADY high; read_done=1 and rdata_out updated for the cycle after T+4.
REQ-021 The master SHALL hold VALID signals and payload stable until READY; the slave SHALL accept AW and W only together.
REQ-022 Register index SHALL be addr[2+log2(NUM_REGS)-1:2]; addr[1:0] is ignored; writes are full-word (all strobes set).
REQ-023 error SHALL be registered at completion as resp[1] and held until the next completion.
REQ-024 busy SHALL be 1 in every non-IDLE state and 0 in IDLE, including the cycle in which done is pulsed.
REQ-025 Reading a register that has never been written SHALL return 0.

Reset
REQ-026 reset=0 SHALL asynchronously force: FSM to IDLE; all VALID/READY signals to 0; rdata_out, read_done, write_done, busy, error to 0; all slave registers to 0.
REQ-027 Reset asserted mid-transaction SHALL abort it without producing any done pulse; the first request after release starts cleanly.

Configuration
REQ-028 Macro AXIL_ADDR_CHECK_EN defined: an address with any bit set at or above bit 2+log2(NUM_REGS) SHALL return SLVERR; the write is discarded, RDATA=0, and error=1 at completion. Timing is unchanged.
REQ-029 Macro not defined: upper address bits SHALL be ignored (aliasing), and the response SHALL always be OKAY.

Verification
REQ-030 Reset release, write addr=0x10, data=0xAABBCCDD -> write_done pulses after 4 cycles, error=0, busy falls.
REQ-031 Read addr=0x10 -> read_done pulses after 4 cycles, rdata_out=0xAABBCCDD, error=0.
REQ-032 Read addr=0x04 after reset -> rdata_out=0x00000000, error=0.
REQ-033 wr_en and rd_en together (addr=0x08, data=0x12345678) -> only write_done pulses; a later read of 0x08 returns 0x12345678; wr_en pulsed while busy is ignored.
REQ-034 With AXIL_ADDR_CHECK_EN, write then read addr=0x100 -> error=1 on both, rdata_out=0; without the macro, the read of 0x100 returns the data written to 0x00.
REQ-035 reset asserted during WR_RESP -> no write_done, outputs 0; a subsequent read returns 0.
